// File: rtl/output_buffer.sv
// Write-side staging FIFO that cuts the output region into <=4 KiB bursts.
// Optional sticky overflow detection: define OBUF_OVERFLOW_CHK_EN.
module output_buffer #(
    parameter int DATA_WIDTH      = 512,
    parameter int FIFO_ADDR_WIDTH = 7,
    parameter int BURST_LENGTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_start,
    input  logic                  end_conv,
    input  logic [31:0]           output_byte,
    input  logic [63:0]           addr_base,
    input  logic                  push_req,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  full,
    output logic                  wmst_req,
    input  logic                  wmst_done,
    output logic [63:0]           addr_offset,
    output logic [63:0]           xfer_size,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  busy,
    output logic                  op_done,
    output logic                  overflow
);

    localparam int DWB   = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int BLB   = DWB * BURST_LENGTH;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int CW    = FIFO_ADDR_WIDTH + 1;
    localparam int BW    = $clog2(BURST_LENGTH + 1);

    typedef enum logic [2:0] {
        IDLE, FILL, REQ, XFER, WAIT_DONE, FIN
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_next;
    logic           push, pop, clr;

    logic [31:0]    rem_bytes, burst_bytes;
    logic [63:0]    cur_addr;
    logic [BW-1:0]  burst_beats, beat_cnt;
    logic           flush_lat, flush;

    logic [31:0]    full_bytes, full_beats, cnt_bytes;
    logic [31:0]    fl_bytes, sel_bytes, rem_after;
    logic [BW-1:0]  sel_beats;
    logic           thresh, last_beat;

    assign push  = push_req & ~full;
    assign pop   = tvalid & tready;
    assign clr   = (state == FIN);
    assign flush = flush_lat | end_conv;

    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // A flush burst takes whatever is buffered, capped by what remains.
    always_comb begin
        full_bytes = (rem_bytes > 32'(BLB)) ? 32'(BLB) : rem_bytes;
        full_beats = (full_bytes + 32'(DWB - 1)) / 32'(DWB);
        cnt_bytes  = 32'(count) * 32'(DWB);
        fl_bytes   = (cnt_bytes < rem_bytes) ? cnt_bytes : rem_bytes;
        thresh     = (32'(count) >= full_beats);
        sel_bytes  = thresh ? full_bytes : fl_bytes;
        sel_beats  = BW'((sel_bytes + 32'(DWB - 1)) / 32'(DWB));
        rem_after  = (rem_bytes > burst_bytes) ?
                     (rem_bytes - burst_bytes) : 32'd0;
    end

    assign tvalid    = (state == XFER) && (count != '0) &&
                       (beat_cnt < burst_beats);
    assign tdata     = tvalid ? mem[rd_ptr] : '0;
    assign last_beat = pop && (beat_cnt == burst_beats - BW'(1));
    assign wmst_req  = (state == REQ);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (op_start)
                    next_state = (output_byte != '0) ? FILL : FIN;
            FILL:
                if (thresh)
                    next_state = REQ;
                else if (flush)
                    next_state = (count != '0) ? REQ : FIN;
            REQ:
                next_state = XFER;
            XFER:
                if (last_beat) next_state = WAIT_DONE;
            WAIT_DONE:
                if (wmst_done)
                    next_state = (rem_after == '0 || flush) ? FIN : FILL;
            FIN:
                next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_bytes   <= '0;
            cur_addr    <= '0;
            burst_bytes <= '0;
            burst_beats <= '0;
            beat_cnt    <= '0;
            flush_lat   <= 1'b0;
            addr_offset <= '0;
            xfer_size   <= '0;
            op_done     <= 1'b0;
        end else begin
            state   <= next_state;
            op_done <= (state == FIN);
            if (state == IDLE && op_start) begin
                rem_bytes <= output_byte;
                cur_addr  <= addr_base;
            end
            if (state == FILL && next_state == REQ) begin
                burst_bytes <= sel_bytes;
                burst_beats <= sel_beats;
                addr_offset <= cur_addr;
                xfer_size   <= 64'(sel_bytes);
            end
            if (state == REQ)
                beat_cnt <= '0;
            else if (pop)
                beat_cnt <= beat_cnt + BW'(1);
            if (state == WAIT_DONE && wmst_done) begin
                cur_addr  <= cur_addr + 64'(burst_bytes);
                rem_bytes <= rem_after;
            end
            if (clr)
                flush_lat <= 1'b0;
            else if (state != IDLE && end_conv)
                flush_lat <= 1'b1;
        end
    end

`ifdef OBUF_OVERFLOW_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (state == IDLE && op_start)
            overflow <= 1'b0;
        else if (push_req && full)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer.
// Overflow expectations follow OBUF_OVERFLOW_CHK_EN.
module tb_output_buffer;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_start = 1'b0;
    logic          end_conv = 1'b0;
    logic [31:0]   output_byte = '0;
    logic [63:0]   addr_base = '0;
    logic          push_req = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          full;
    logic          wmst_req;
    logic          wmst_done = 1'b0;
    logic [63:0]   addr_offset;
    logic [63:0]   xfer_size;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          busy;
    logic          op_done;
    logic          overflow;

    output_buffer dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start),
        .end_conv(end_conv), .output_byte(output_byte),
        .addr_base(addr_base), .push_req(push_req), .i_data(i_data),
        .full(full), .wmst_req(wmst_req), .wmst_done(wmst_done),
        .addr_offset(addr_offset), .xfer_size(xfer_size),
        .tdata(tdata), .tvalid(tvalid), .tready(tready),
        .busy(busy), .op_done(op_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    logic [63:0]   c_addr, c_size;
    int            stall_viol, xfer_cycles;
    bit            c_ok;

`ifdef OBUF_OVERFLOW_CHK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    function automatic logic [DW-1:0] word(input int v);
        return {16{v}};
    endfunction

    function automatic int data_mism();
        int m = 0;
        foreach (got_q[i]) begin
            if (exp_q.size() == 0) m++;
            else if (got_q[i] !== exp_q.pop_front()) m++;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            push_req = 1'b1;
            i_data = word(base + i);
            exp_q.push_back(word(base + i));
            tick();
        end
        push_req = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] b, input logic [63:0] a);
        output_byte = b;
        addr_base = a;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
    endtask

    // Waits for a burst request, then drains exp_beats beats.
    task automatic collect(input int exp_beats, input bit toggle);
        int n = 0;
        int t = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] held = '0;
        c_ok = 1'b0;
        stall_viol = 0;
        xfer_cycles = 0;
        got_q.delete();
        for (int i = 0; i < 3000 && !wmst_req; i++) tick();
        if (!wmst_req) return;
        c_addr = addr_offset;
        c_size = xfer_size;
        tick();
        while (n < exp_beats && t < 3000) begin
            tready = toggle ? t[0] : 1'b1;
            if (stalled && (!tvalid || tdata !== held)) stall_viol++;
            stalled = tvalid && !tready;
            held = tdata;
            if (tvalid && tready) begin
                got_q.push_back(tdata);
                n++;
            end
            t++;
            tick();
        end
        tready = 1'b0;
        xfer_cycles = t;
        c_ok = (n == exp_beats);
    endtask

    task automatic finish_burst();
        wmst_done = 1'b1;
        tick();
        wmst_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wmst_req, tvalid, busy, op_done, overflow, full} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0",
                {wmst_req, tvalid, busy, op_done, overflow, full});
        end
        checks++;
        if (addr_offset !== 64'd0 || xfer_size !== 64'd0) begin
            errors++;
            $display("FAIL reset_regs got=%0h/%0h exp=0/0",
                addr_offset, xfer_size);
        end
        checks++;
        if (tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata got=%0h exp=0", tdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_bursts();
        exp_q.delete();
        push_words(128, 32'h100);
        start_op(32'd8192, 64'h1000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL two_busy got=%b exp=1", busy);
        end
        for (int b = 0; b < 2; b++) begin
            collect(64, 1'b0);
            checks++;
            if (!c_ok) begin
                errors++;
                $display("FAIL two_beats%0d got=%0d exp=64", b, got_q.size());
            end
            checks++;
            if (c_addr !== 64'h1000 + 64'(b) * 64'h1000 || c_size !== 64'd4096) begin
                errors++;
                $display("FAIL two_req%0d got=%0h/%0d exp=%0h/4096",
                    b, c_addr, c_size, 64'h1000 + 64'(b) * 64'h1000);
            end
            checks++;
            if (data_mism() != 0) begin
                errors++;
                $display("FAIL two_data%0d got=mism exp=push order", b);
            end
            finish_burst();
        end
        checks++;
        if (op_done !== 1'b0) begin
            errors++;
            $display("FAIL two_done_early got=%b exp=0", op_done);
        end
        tick();
        checks++;
        if (op_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL two_done got=%b/%b exp=1/0", op_done, busy);
        end
    endtask

    task automatic test_partial_burst();
        exp_q.delete();
        push_words(65, 32'h2000);
        start_op(32'd4160, 64'h4000);
        collect(64, 1'b0);
        checks++;
        if (!c_ok || c_addr !== 64'h4000 || c_size !== 64'd4096) begin
            errors++;
            $display("FAIL part_b1 got=%0h/%0d/%0d exp=4000/4096/64",
                c_addr, c_size, got_q.size());
        end
        checks++;
        if (data_mism() != 0) begin
            errors++;
            $display("FAIL part_data1 got=mism exp=push order");
        end
        finish_burst();
        collect(1, 1'b0);
        checks++;
        if (!c_ok || c_addr !== 64'h5000 || c_size !== 64'd64) begin
            errors++;
            $display("FAIL part_b2 got=%0h/%0d/%0d exp=5000/64/1",
                c_addr, c_size, got_q.size());
        end
        checks++;
        if (data_mism() != 0) begin
            errors++;
            $display("FAIL part_data2 got=mism exp=word 0x2040");
        end
        finish_burst();
        tick();
        checks++;
        if (op_done !== 1'b1) begin
            errors++;
            $display("FAIL part_done got=%b exp=1", op_done);
        end
    endtask

    task automatic test_stall();
        exp_q.delete();
        push_words(64, 32'h3000);
        start_op(32'd4096, 64'h8000);
        collect(64, 1'b1);
        checks++;
        if (!c_ok || xfer_cycles != 128) begin
            errors++;
            $display("FAIL stall_cycles got=%0d exp=128", xfer_cycles);
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_hold got=%0d exp=0", stall_viol);
        end
        checks++;
        if (data_mism() != 0) begin
            errors++;
            $display("FAIL stall_data got=mism exp=push order");
        end
        finish_burst();
        tick();
        checks++;
        if (op_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got=%b exp=1", op_done);
        end
    endtask

    task automatic test_flush();
        exp_q.delete();
        start_op(32'd8192, 64'h20000);
        push_words(10, 32'h4000);
        repeat (3) tick();
        checks++;
        if (wmst_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_early got=%b exp=0", wmst_req);
        end
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        collect(10, 1'b0);
        checks++;
        if (!c_ok || c_addr !== 64'h20000 || c_size !== 64'd640) begin
            errors++;
            $display("FAIL flush_req got=%0h/%0d/%0d exp=20000/640/10",
                c_addr, c_size, got_q.size());
        end
        checks++;
        if (data_mism() != 0) begin
            errors++;
            $display("FAIL flush_data got=mism exp=push order");
        end
        finish_burst();
        tick();
        checks++;
        if (op_done !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_done got=%b/%b/%b exp=1/0/0",
                op_done, busy, full);
        end
    endtask

    task automatic test_zero_bytes();
        bit saw_req;
        start_op(32'd0, 64'h40);
        saw_req = wmst_req;
        checks++;
        if (busy !== 1'b1 || op_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_c1 got=%b/%b exp=1/0", busy, op_done);
        end
        tick();
        saw_req = saw_req | wmst_req;
        checks++;
        if (op_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got=%b/%b exp=1/0", op_done, busy);
        end
        tick();
        checks++;
        if (saw_req || op_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_req got=%b/%b exp=0/0", saw_req, op_done);
        end
    endtask

    task automatic test_overflow();
        exp_q.delete();
        push_words(127, 32'h5000);
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full127 got=%b exp=0", full);
        end
        push_words(1, 32'h5000 + 127);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full128 got=%b exp=1", full);
        end
        push_req = 1'b1;
        i_data = word(32'hdead);
        tick();
        push_req = 1'b0;
        tick();
        checks++;
        if (overflow !== EXP_OVF || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b/%b exp=%b/1",
                overflow, full, EXP_OVF);
        end
        start_op(32'd8192, 64'h0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
        for (int b = 0; b < 2; b++) begin
            collect(64, 1'b0);
            checks++;
            if (!c_ok || data_mism() != 0) begin
                errors++;
                $display("FAIL ovf_data%0d got=mism exp=push order", b);
            end
            finish_burst();
        end
        tick();
        checks++;
        if (op_done !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done got=%b exp=1", op_done);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_req = 1'b0;
        exp_q.delete();
        start_op(32'd4096, 64'h9000);
        push_words(64, 32'h6000);
        for (int i = 0; i < 20 && !wmst_req; i++) tick();
        tick();
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL abort_xfer got=%b exp=1", tvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || addr_offset !== 64'd0) begin
            errors++;
            $display("FAIL abort_rst got=%b/%b/%0h exp=0/0/0",
                tvalid, busy, addr_offset);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_req = saw_req | wmst_req | busy;
        end
        checks++;
        if (saw_req) begin
            errors++;
            $display("FAIL abort_idle got=1 exp=0");
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_partial_burst();
        test_stall();
        test_flush();
        test_zero_bytes();
        test_overflow();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors",
            checks, errors);
        $finish;
    end

endmodule
